// File: rtl/spmv_mem_pkg.sv
// Shared definitions for the SpMV memory arbiter: widths, store stride,
// load-tag bit layout, FSM state encoding and pop-source encoding.
package spmv_mem_pkg;

    localparam int unsigned MAX_OUT_DEFAULT = 32;
    localparam int unsigned ADDR_W          = 48;
    localparam int unsigned DATA_W          = 64;
    localparam int unsigned ST_STRIDE       = 8;

    // Load tag layout: bit0 selects cache (1) or decoder (0);
    // bits [2:1] carry the decoder's own tag.
    localparam int unsigned TAG_SRC_BIT = 0;
    localparam int unsigned TAG_DEC_LSB = 1;
    localparam int unsigned TAG_DEC_MSB = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_RUN   = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ST   = 2'd1,
        SRC_CL   = 2'd2,
        SRC_DL   = 2'd3
    } pop_src_t;

    // Build the d_or_tag word carried by a load request.
    function automatic logic [DATA_W-1:0] load_tag(input logic i_cache, input logic [1:0] i_dtag);
        logic [DATA_W-1:0] tag;
        tag = '0;
        if (i_cache) begin
            tag[TAG_SRC_BIT] = 1'b1;
        end else begin
            tag[TAG_DEC_MSB:TAG_DEC_LSB] = i_dtag;
        end
        return tag;
    endfunction

endpackage

// File: rtl/spmv_credit_counter.sv
// Outstanding-load counter: +1 per load pop, -1 per memory response,
// saturating at 0 and at MAX_OUT.
module spmv_credit_counter
    import spmv_mem_pkg::*;
#(
    parameter int unsigned MAX_OUT = MAX_OUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_avail,
    output logic o_nonzero
);

    localparam int unsigned    CW    = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(MAX_OUT);

    logic [CW-1:0] r_count;

    // Count loads in flight; simultaneous inc and dec cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            if (r_count != LIMIT) begin
                r_count <= r_count + 1'b1;
            end
        end else if (i_dec && !i_inc) begin
            if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_avail   = (r_count < LIMIT);
    assign o_nonzero = (r_count != '0);

endmodule

// File: rtl/spmv_mem_arbiter.sv
// SpMV memory arbiter: merges a store stream (bounded address window) with
// two load FIFOs onto one memory request port and routes load responses
// back to the cache or decoder by tag.
module spmv_mem_arbiter
    import spmv_mem_pkg::*;
#(
    parameter int unsigned MAX_OUT = MAX_OUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_ld,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_end,
    input  logic              st_valid,
    output logic              st_pop,
    input  logic [DATA_W-1:0] st_data,
    input  logic              cl_valid,
    output logic              cl_pop,
    input  logic [ADDR_W-1:0] cl_addr,
    input  logic              dl_valid,
    output logic              dl_pop,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [1:0]        dl_tag,
    output logic              req_mem_ld,
    output logic              req_mem_st,
    output logic [ADDR_W-1:0] req_mem_addr,
    output logic [DATA_W-1:0] req_mem_d_or_tag,
    input  logic              req_mem_stall,
    input  logic              rsp_mem_push,
    input  logic [2:0]        rsp_mem_tag,
    input  logic [DATA_W-1:0] rsp_mem_q,
    output logic              rsp_mem_stall,
    input  logic              rsp_downstream_full,
    output logic              cache_rsp_push,
    output logic              dec_rsp_push,
    output logic [1:0]        rsp_tag,
    output logic [DATA_W-1:0] rsp_q,
    output logic              busy
);

    arb_state_t        r_state;
    logic [ADDR_W-1:0] r_st_addr;
    logic [ADDR_W-1:0] r_end;
    logic              r_rr_dl;

    pop_src_t          r_s1_src;
    logic [ADDR_W-1:0] r_s1_addr;

    logic              r_req_ld;
    logic              r_req_st;
    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_req_d;

    logic              r_rsp_stall;
    logic              r_cache_push;
    logic              r_dec_push;
    logic [1:0]        r_rsp_tag;
    logic [DATA_W-1:0] r_rsp_q;

    pop_src_t          w_grant;
    logic              w_pop_ok;
    logic              w_st_ok;
    logic              w_credit_avail;
    logic              w_outstanding_nz;
    logic              w_ld_pop;

    assign w_pop_ok = !rst && !req_mem_stall;
    assign w_st_ok  = (r_state == ARB_RUN) && (r_st_addr != r_end) && st_valid;
    assign w_ld_pop = (w_grant == SRC_CL) || (w_grant == SRC_DL);

    // Pick at most one FIFO to pop: stores first, then round-robin loads.
    always_comb begin
        w_grant = SRC_NONE;
        if (w_pop_ok) begin
            if (w_st_ok) begin
                w_grant = SRC_ST;
            end else if (w_credit_avail) begin
                if (r_rr_dl) begin
                    if (dl_valid)      w_grant = SRC_DL;
                    else if (cl_valid) w_grant = SRC_CL;
                end else begin
                    if (cl_valid)      w_grant = SRC_CL;
                    else if (dl_valid) w_grant = SRC_DL;
                end
            end
        end
    end

    assign st_pop = (w_grant == SRC_ST);
    assign cl_pop = (w_grant == SRC_CL);
    assign dl_pop = (w_grant == SRC_DL);

    spmv_credit_counter #(
        .MAX_OUT (MAX_OUT)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .i_inc     (w_ld_pop),
        .i_dec     (rsp_mem_push),
        .o_avail   (w_credit_avail),
        .o_nonzero (w_outstanding_nz)
    );

    // Store-window FSM; a reload from any state restarts the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_st_addr <= '0;
            r_end     <= '0;
        end else if (cfg_ld) begin
            r_state   <= ARB_RUN;
            r_st_addr <= cfg_base;
            r_end     <= cfg_end;
        end else begin
            case (r_state)
                ARB_RUN: begin
                    if (st_pop) begin
                        r_st_addr <= r_st_addr + ADDR_W'(ST_STRIDE);
                    end
                    if (r_st_addr == r_end) begin
                        r_state <= ARB_DRAIN;
                    end
                end
                ARB_DRAIN: begin
                    if (!w_outstanding_nz) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    // Round-robin pointer hands priority to the other load FIFO after a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_dl <= 1'b0;
        end else if (w_grant == SRC_CL) begin
            r_rr_dl <= 1'b1;
        end else if (w_grant == SRC_DL) begin
            r_rr_dl <= 1'b0;
        end
    end

    // Two-stage request pipeline: remember the pop, then merge FIFO data
    // (valid one cycle after the pop) into the registered request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_src   <= SRC_NONE;
            r_s1_addr  <= '0;
            r_req_ld   <= 1'b0;
            r_req_st   <= 1'b0;
            r_req_addr <= '0;
            r_req_d    <= '0;
        end else begin
            r_s1_src   <= w_grant;
            r_s1_addr  <= r_st_addr;
            r_req_ld   <= 1'b0;
            r_req_st   <= 1'b0;
            r_req_addr <= '0;
            r_req_d    <= '0;
            case (r_s1_src)
                SRC_ST: begin
                    r_req_st   <= 1'b1;
                    r_req_addr <= r_s1_addr;
                    r_req_d    <= st_data;
                end
                SRC_CL: begin
                    r_req_ld   <= 1'b1;
                    r_req_addr <= cl_addr;
                    r_req_d    <= load_tag(1'b1, 2'b00);
                end
                SRC_DL: begin
                    r_req_ld   <= 1'b1;
                    r_req_addr <= dl_addr;
                    r_req_d    <= load_tag(1'b0, dl_tag);
                end
                default: ;
            endcase
        end
    end

    // Register responses and steer the push strobe by the source tag bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_stall  <= 1'b0;
            r_cache_push <= 1'b0;
            r_dec_push   <= 1'b0;
            r_rsp_tag    <= '0;
            r_rsp_q      <= '0;
        end else begin
            r_rsp_stall  <= rsp_downstream_full;
            r_cache_push <= rsp_mem_push &  rsp_mem_tag[TAG_SRC_BIT];
            r_dec_push   <= rsp_mem_push & ~rsp_mem_tag[TAG_SRC_BIT];
            r_rsp_tag    <= rsp_mem_tag[TAG_DEC_MSB:TAG_DEC_LSB];
            r_rsp_q      <= rsp_mem_q;
        end
    end

    assign req_mem_ld       = r_req_ld;
    assign req_mem_st       = r_req_st;
    assign req_mem_addr     = r_req_addr;
    assign req_mem_d_or_tag = r_req_d;
    assign rsp_mem_stall    = r_rsp_stall;
    assign cache_rsp_push   = r_cache_push;
    assign dec_rsp_push     = r_dec_push;
    assign rsp_tag          = r_rsp_tag;
    assign rsp_q            = r_rsp_q;
    assign busy             = (r_state != ARB_IDLE) || w_outstanding_nz;

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Self-checking bench for spmv_mem_arbiter: FIFO models feed the arbiter,
// every pop pushes the expected memory request onto a scoreboard queue and
// every response pushes the expected routed response.
module tb_spmv_mem_arbiter;

    localparam int unsigned TB_MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_ld;
    logic [47:0] cfg_base;
    logic [47:0] cfg_end;
    logic        st_valid;
    logic        st_pop;
    logic [63:0] st_data;
    logic        cl_valid;
    logic        cl_pop;
    logic [47:0] cl_addr;
    logic        dl_valid;
    logic        dl_pop;
    logic [47:0] dl_addr;
    logic [1:0]  dl_tag;
    logic        req_mem_ld;
    logic        req_mem_st;
    logic [47:0] req_mem_addr;
    logic [63:0] req_mem_d_or_tag;
    logic        req_mem_stall;
    logic        rsp_mem_push;
    logic [2:0]  rsp_mem_tag;
    logic [63:0] rsp_mem_q;
    logic        rsp_mem_stall;
    logic        rsp_downstream_full;
    logic        cache_rsp_push;
    logic        dec_rsp_push;
    logic [1:0]  rsp_tag;
    logic [63:0] rsp_q;
    logic        busy;

    spmv_mem_arbiter #(
        .MAX_OUT (TB_MAX_OUT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cfg_ld              (cfg_ld),
        .cfg_base            (cfg_base),
        .cfg_end             (cfg_end),
        .st_valid            (st_valid),
        .st_pop              (st_pop),
        .st_data             (st_data),
        .cl_valid            (cl_valid),
        .cl_pop              (cl_pop),
        .cl_addr             (cl_addr),
        .dl_valid            (dl_valid),
        .dl_pop              (dl_pop),
        .dl_addr             (dl_addr),
        .dl_tag              (dl_tag),
        .req_mem_ld          (req_mem_ld),
        .req_mem_st          (req_mem_st),
        .req_mem_addr        (req_mem_addr),
        .req_mem_d_or_tag    (req_mem_d_or_tag),
        .req_mem_stall       (req_mem_stall),
        .rsp_mem_push        (rsp_mem_push),
        .rsp_mem_tag         (rsp_mem_tag),
        .rsp_mem_q           (rsp_mem_q),
        .rsp_mem_stall       (rsp_mem_stall),
        .rsp_downstream_full (rsp_downstream_full),
        .cache_rsp_push      (cache_rsp_push),
        .dec_rsp_push        (dec_rsp_push),
        .rsp_tag             (rsp_tag),
        .rsp_q               (rsp_q),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        ld;
        logic        st;
        logic [47:0] addr;
        logic [63:0] d;
    } req_exp_t;

    typedef struct {
        int          due;
        logic        cpush;
        logic        dpush;
        logic [1:0]  tag;
        logic [63:0] q;
    } rsp_exp_t;

    req_exp_t req_sb[$];
    rsp_exp_t rsp_sb[$];
    int       pop_log[$];   // 1 = store, 2 = cache load, 3 = decoder load

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          outstanding = 0;
    int          st_left = 0, cl_left = 0, dl_left = 0;
    int          st_seq = 0, cl_seq = 0, dl_seq = 0;
    logic [47:0] exp_st_addr = '0;
    logic        exp_rms = 1'b0;
    logic        mon_en = 1'b0;
    logic        s_busy, s_req_ld, s_req_st;

    function automatic logic [63:0] st_word(input int i);
        return 64'hDA7A_0000_0000_0000 | 64'(i);
    endfunction

    function automatic logic [47:0] cl_word(input int i);
        return 48'h00C0_0000_0000 + (48'(i) << 3);
    endfunction

    function automatic logic [47:0] dl_word(input int i);
        return 48'h00D0_0000_0000 + (48'(i) << 3);
    endfunction

    function automatic logic [1:0] dl_tagv(input int i);
        logic [31:0] v;
        v = i;
        return v[1:0];
    endfunction

    function automatic int count_kind(input int kind);
        int n;
        n = 0;
        foreach (pop_log[k]) if (pop_log[k] == kind) n++;
        return n;
    endfunction

    task automatic set_fifos(input int s, input int c, input int d);
        st_left = s; cl_left = c; dl_left = d;
        st_valid = (s > 0); cl_valid = (c > 0); dl_valid = (d > 0);
    endtask

    // One clock cycle: monitor at the falling edge, FIFO data update after the rising edge.
    task automatic step();
        logic     p_st, p_cl, p_dl;
        int       i_st, i_cl, i_dl, npop;
        req_exp_t re;
        rsp_exp_t rp;
        i_st = 0; i_cl = 0; i_dl = 0;
        @(negedge clk);
        cyc++;
        p_st = st_pop; p_cl = cl_pop; p_dl = dl_pop;
        s_busy = busy; s_req_ld = req_mem_ld; s_req_st = req_mem_st;
        if (mon_en) begin
            if (req_sb.size() > 0 && req_sb[0].due == cyc) begin
                re = req_sb.pop_front();
                n_checks++;
                if (req_mem_ld !== re.ld || req_mem_st !== re.st ||
                    req_mem_addr !== re.addr || req_mem_d_or_tag !== re.d) begin
                    n_fail++;
                    $display("FAIL req_mem @%0d: got ld=%b st=%b addr=%h d=%h, expected ld=%b st=%b addr=%h d=%h",
                             cyc, req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag,
                             re.ld, re.st, re.addr, re.d);
                end
            end else begin
                n_checks++;
                if (req_mem_ld !== 1'b0 || req_mem_st !== 1'b0) begin
                    n_fail++;
                    $display("FAIL req_idle @%0d: got ld=%b st=%b, expected 0 0", cyc, req_mem_ld, req_mem_st);
                end
            end
            if (rsp_sb.size() > 0 && rsp_sb[0].due == cyc) begin
                rp = rsp_sb.pop_front();
                n_checks++;
                if (cache_rsp_push !== rp.cpush || dec_rsp_push !== rp.dpush ||
                    rsp_tag !== rp.tag || rsp_q !== rp.q) begin
                    n_fail++;
                    $display("FAIL rsp_route @%0d: got c=%b d=%b tag=%b q=%h, expected c=%b d=%b tag=%b q=%h",
                             cyc, cache_rsp_push, dec_rsp_push, rsp_tag, rsp_q,
                             rp.cpush, rp.dpush, rp.tag, rp.q);
                end
            end else begin
                n_checks++;
                if (cache_rsp_push !== 1'b0 || dec_rsp_push !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rsp_idle @%0d: got c=%b d=%b, expected 0 0", cyc, cache_rsp_push, dec_rsp_push);
                end
            end
            n_checks++;
            if (rsp_mem_stall !== exp_rms) begin
                n_fail++;
                $display("FAIL rsp_mem_stall @%0d: got %b, expected %b", cyc, rsp_mem_stall, exp_rms);
            end
            npop = int'(p_st) + int'(p_cl) + int'(p_dl);
            n_checks++;
            if (npop > 1 || ((rst || req_mem_stall) && npop != 0)) begin
                n_fail++;
                $display("FAIL pop_legal @%0d: got pops st=%b cl=%b dl=%b (rst=%b stall=%b), expected at most one and none under rst/stall",
                         cyc, p_st, p_cl, p_dl, rst, req_mem_stall);
            end
        end
        exp_rms = rst ? 1'b0 : rsp_downstream_full;
        if (p_st) begin
            re = '{due: cyc + 2, ld: 1'b0, st: 1'b1, addr: exp_st_addr, d: st_word(st_seq)};
            req_sb.push_back(re);
            i_st = st_seq; st_seq++; st_left--;
            exp_st_addr = exp_st_addr + 48'd8;
            pop_log.push_back(1);
        end
        if (p_cl) begin
            re = '{due: cyc + 2, ld: 1'b1, st: 1'b0, addr: cl_word(cl_seq), d: 64'd1};
            req_sb.push_back(re);
            i_cl = cl_seq; cl_seq++; cl_left--; outstanding++;
            pop_log.push_back(2);
        end
        if (p_dl) begin
            re = '{due: cyc + 2, ld: 1'b1, st: 1'b0, addr: dl_word(dl_seq), d: {61'd0, dl_tagv(dl_seq), 1'b0}};
            req_sb.push_back(re);
            i_dl = dl_seq; dl_seq++; dl_left--; outstanding++;
            pop_log.push_back(3);
        end
        if (cfg_ld && !rst) exp_st_addr = cfg_base;
        if (rsp_mem_push) begin
            rp = '{due: cyc + 1, cpush: rsp_mem_tag[0], dpush: ~rsp_mem_tag[0], tag: rsp_mem_tag[2:1], q: rsp_mem_q};
            rsp_sb.push_back(rp);
            if (outstanding > 0) outstanding--;
        end
        if (rst) begin
            req_sb.delete();
            rsp_sb.delete();
            outstanding = 0;
        end
        @(posedge clk);
        #1;
        st_data = p_st ? st_word(i_st) : {$urandom, $urandom};
        cl_addr = p_cl ? cl_word(i_cl) : 48'({$urandom, $urandom});
        dl_addr = p_dl ? dl_word(i_dl) : 48'({$urandom, $urandom});
        dl_tag  = p_dl ? dl_tagv(i_dl) : 2'($urandom);
        st_valid = (st_left > 0);
        cl_valid = (cl_left > 0);
        dl_valid = (dl_left > 0);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic send_rsp(input logic [2:0] tag, input logic [63:0] q);
        rsp_mem_push = 1'b1;
        rsp_mem_tag  = tag;
        rsp_mem_q    = q;
        step();
        rsp_mem_push = 1'b0;
    endtask

    // Wait a bounded number of cycles for busy to drop.
    task automatic expect_idle(input string name);
        for (int k = 0; k < 8; k++) begin
            step();
            if (s_busy === 1'b0) break;
        end
        n_checks++;
        if (s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: busy got %b, expected 0 within 8 cycles", name, s_busy);
        end
    endtask

    task automatic drain(input string name);
        set_fifos(0, 0, 0);
        for (int k = 0; k < 16 && outstanding > 0; k++) begin
            send_rsp((k % 2 == 0) ? 3'b110 : 3'b101, 64'h5EED_0000_0000_0000 + 64'(k));
        end
        expect_idle(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mon_en = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if (s_busy !== 1'b0 || s_req_ld !== 1'b0 || s_req_st !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b ld=%b st=%b, expected 0 0 0", s_busy, s_req_ld, s_req_st);
        end
    endtask

    task automatic test_store_window();
        int exp_seq[7] = '{1, 1, 1, 2, 3, 2, 3};
        pop_log.delete();
        cfg_base = 48'h1000;
        cfg_end  = 48'h1018;
        cfg_ld   = 1'b1;
        step();
        cfg_ld = 1'b0;
        set_fifos(100, 100, 100);
        steps(12);
        n_checks++;
        if (pop_log.size() != 7) begin
            n_fail++;
            $display("FAIL window_pop_count: got %0d pops, expected 7", pop_log.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                n_checks++;
                if (pop_log[k] != exp_seq[k]) begin
                    n_fail++;
                    $display("FAIL window_pop_order[%0d]: got %0d, expected %0d", k, pop_log[k], exp_seq[k]);
                end
            end
        end
        n_checks++;
        if (s_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL window_busy_loads: got %b, expected 1", s_busy);
        end
        set_fifos(0, 0, 0);
        send_rsp(3'b101, 64'h1111_2222_3333_4444);
        send_rsp(3'b110, 64'h5555_6666_7777_8888);
        send_rsp(3'b001, 64'h0123_4567_89AB_CDEF);
        send_rsp(3'b100, 64'hFEDC_BA98_7654_3210);
        n_checks++;
        if (s_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL window_busy_last_rsp: got %b, expected 1", s_busy);
        end
        expect_idle("window_busy_drop");
    endtask

    task automatic test_credit_limit();
        int exp_seq[4] = '{2, 3, 2, 3};
        pop_log.delete();
        set_fifos(0, 100, 100);
        steps(10);
        n_checks++;
        if (pop_log.size() != 4) begin
            n_fail++;
            $display("FAIL credit_limit: got %0d load pops, expected 4", pop_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (pop_log[k] != exp_seq[k]) begin
                    n_fail++;
                    $display("FAIL credit_rr[%0d]: got %0d, expected %0d", k, pop_log[k], exp_seq[k]);
                end
            end
        end
        send_rsp(3'b101, 64'hCAFE_F00D_0000_0001);
        steps(6);
        n_checks++;
        if (pop_log.size() != 5) begin
            n_fail++;
            $display("FAIL credit_refill: got %0d load pops, expected 5", pop_log.size());
        end
        drain("credit_drain");
    endtask

    task automatic test_stall();
        set_fifos(0, 100, 100);
        step();
        req_mem_stall = 1'b1;
        rsp_downstream_full = 1'b1;
        pop_log.delete();
        steps(5);
        n_checks++;
        if (pop_log.size() != 0) begin
            n_fail++;
            $display("FAIL stall_no_pop: got %0d pops, expected 0", pop_log.size());
        end
        req_mem_stall = 1'b0;
        rsp_downstream_full = 1'b0;
        steps(4);
        n_checks++;
        if (pop_log.size() != 3) begin
            n_fail++;
            $display("FAIL stall_resume: got %0d pops, expected 3", pop_log.size());
        end
        drain("stall_drain");
    endtask

    task automatic test_empty_window();
        pop_log.delete();
        cfg_base = 48'h3000;
        cfg_end  = 48'h3000;
        cfg_ld   = 1'b1;
        set_fifos(100, 0, 0);
        step();
        cfg_ld = 1'b0;
        steps(6);
        n_checks++;
        if (count_kind(1) != 0) begin
            n_fail++;
            $display("FAIL empty_window_stores: got %0d store pops, expected 0", count_kind(1));
        end
        n_checks++;
        if (s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_window_idle: busy got %b, expected 0", s_busy);
        end
        set_fifos(0, 0, 0);
    endtask

    task automatic test_reset_midstream();
        cfg_base = 48'h2000;
        cfg_end  = 48'h2100;
        cfg_ld   = 1'b1;
        set_fifos(100, 100, 100);
        step();
        cfg_ld = 1'b0;
        steps(4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_fifos(0, 0, 0);
        step();
        n_checks++;
        if (s_req_ld !== 1'b0 || s_req_st !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_req: got ld=%b st=%b, expected 0 0", s_req_ld, s_req_st);
        end
        n_checks++;
        if (s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got %b, expected 0", s_busy);
        end
        steps(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cfg_ld = 1'b0; cfg_base = '0; cfg_end = '0;
        st_valid = 1'b0; st_data = '0;
        cl_valid = 1'b0; cl_addr = '0;
        dl_valid = 1'b0; dl_addr = '0; dl_tag = '0;
        req_mem_stall = 1'b0;
        rsp_mem_push = 1'b0; rsp_mem_tag = '0; rsp_mem_q = '0;
        rsp_downstream_full = 1'b0;
        test_reset();
        test_store_window();
        test_credit_limit();
        test_stall();
        test_empty_window();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spmv_mem_arbiter.md
SPMV_MEM_ARBITER -- requirements
Module: spmv_mem_arbiter
Interface
REQ-001 SHALL have parameter MAX_OUT, default 32: maximum outstanding loads (cache + decoder).
REQ-002 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port cfg_ld  in  1  load store window; state -> RUN.
REQ-005 SHALL have ports cfg_base  in  48 and cfg_end  in  48: first store byte address and exclusive end address.
REQ-006 SHALL have ports st_valid  in  1 (store FIFO non-empty) and st_pop  out  1 (store FIFO pop).
REQ-007 SHALL have port st_data  in  64  store FIFO q, valid the cycle after st_pop.
REQ-008 SHALL have ports cl_valid  in  1, cl_pop  out  1 and cl_addr  in  48 (q, valid the cycle after pop): cache load FIFO.
REQ-009 SHALL have ports dl_valid  in  1, dl_pop  out  1, dl_addr  in  48 and dl_tag  in  2 (q, valid the cycle after pop): decoder load FIFO.
REQ-010 SHALL have ports req_mem_ld  out  1, req_mem_st  out  1, req_mem_addr  out  48 and req_mem_d_or_tag  out  64: registered memory request.
REQ-011 SHALL have port req_mem_stall  in  1  memory back-pressure.
REQ-012 SHALL have ports rsp_mem_push  in  1, rsp_mem_tag  in  3 and rsp_mem_q  in  64: memory response.
REQ-013 SHALL have port rsp_mem_stall  out  1  registered copy of rsp_downstream_full.
REQ-014 SHALL have port rsp_downstream_full  in  1  OR of consumer almost-full flags.
REQ-015 SHALL have ports cache_rsp_push  out  1 and dec_rsp_push  out  1: routed response strobes.
REQ-016 SHALL have ports rsp_tag  out  2 and rsp_q  out  64: registered rsp_mem_tag[2:1] and rsp_mem_q.
REQ-017 SHALL have port busy  out  1: state != IDLE or outstanding != 0.
Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN: IDLE/RUN/DRAIN -> RUN on cfg_ld (reloads base/end; outstanding count kept); RUN -> DRAIN when st_addr == cfg_end; DRAIN -> IDLE when outstanding == 0.
REQ-019 SHALL assert at most one pop per cycle, and none when req_mem_stall or rst is high.
REQ-020 SHALL use priority: store (RUN only, st_addr != cfg_end) > loads; between cl and dl round-robin, pointer moves to the other requester after each load grant.
REQ-021 SHALL grant a load only if outstanding < MAX_OUT; counter +1 on load pop, -1 on rsp_mem_push, unchanged on both, never below 0.
REQ-022 SHALL present req_mem_* two cycles after the pop (pop N, FIFO q N+1, registered output N+2); ld/st are 0 on all other cycles.
REQ-023 SHALL issue stores with addr = st_addr captured at pop and d_or_tag = st_data; st_addr += 8 per store pop.
REQ-024 SHALL encode load tags: cache d_or_tag = 1 (bit0=1); decoder bit0=0, [2:1]=dl_tag; all other bits 0.
REQ-025 SHALL route responses with one-cycle latency: cache_rsp_push = push & tag[0], dec_rsp_push = push & ~tag[0].
REQ-026 SHALL go RUN -> DRAIN on the cycle after cfg_ld when cfg_base == cfg_end, issuing zero stores.
Reset
REQ-027 SHALL on rst zero all outputs, counter, st_addr and pipeline stages, set state IDLE and pointer to cl; pops in flight are discarded (no req_mem_* the following cycle).
Structure
REQ-028 SHALL take the state encoding, tag bit positions, store stride 8 and MAX_OUT default from shared package spmv_mem_pkg.
REQ-029 SHALL place the outstanding-load counter in sub-module spmv_credit_counter.
Verification
REQ-030 SHALL cover: all three valid every cycle, no stall -> pops st,st,... until window end, then cl,dl,cl,dl alternating.
REQ-031 SHALL cover: cfg_base=0x1000, cfg_end=0x1018, 3 stores -> st addrs 0x1000/0x1008/0x1010, DRAIN, busy drops once outstanding is 0.
REQ-032 SHALL cover: MAX_OUT=4, no responses -> exactly 4 load pops, then none until a response returns, then one more.
REQ-033 SHALL cover: req_mem_stall held 5 cycles -> zero pops during the hold; pops already in flight still emerge.
REQ-034 SHALL cover: rsp tag=3'b101 -> cache_rsp_push; tag=3'b110 -> dec_rsp_push with rsp_tag=2'b11, one cycle later; rst mid-stream -> no req next cycle, busy=0.
